// File: rtl/layer_pkg.sv
// Shared fixed-point helpers for the feature-map layers: Q-format defaults,
// tree sizing formulas, leaky ReLU and saturation on a wide signed carrier.
package layer_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int FRAC_BITS_DEF  = 8;
    localparam int NUM_CH_DEF     = 32;

    // Every intermediate is widened to this carrier before activation/saturation.
    localparam int CALC_W = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic int tree_depth(input int num_ch);
        return $clog2(num_ch);
    endfunction

    function automatic int acc_width(input int data_width, input int num_ch);
        return data_width + $clog2(num_ch) + 1;
    endfunction

    function automatic calc_t leaky(input calc_t x, input int shift);
        calc_t r;
        r = x;
        if (x < 0) begin
            r = x >>> shift;
        end
        return r;
    endfunction

    function automatic calc_t sat_to_width(input calc_t x, input int width);
        calc_t hi;
        calc_t lo;
        calc_t r;
        hi = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
        lo = ~hi;
        r  = x;
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/featuremap_add_level.sv
// One registered level of the channel-reduction tree: adds adjacent pairs of
// signed lanes, growing each result by one bit so the sum can never overflow.
module featuremap_add_level #(
    parameter int N_IN     = 2,
    parameter int IN_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic                                valid_i,
    input  logic [N_IN*IN_WIDTH-1:0]            data_i,
    output logic                                valid_o,
    output logic [(N_IN/2)*(IN_WIDTH+1)-1:0]    data_o
);

    localparam int N_OUT  = N_IN / 2;
    localparam int OUT_W  = IN_WIDTH + 1;

    logic [N_OUT*OUT_W-1:0] pair_sum;
    logic [N_OUT*OUT_W-1:0] data_d;
    logic [N_OUT*OUT_W-1:0] data_q;
    logic                   valid_d;
    logic                   valid_q;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pair
            logic [IN_WIDTH-1:0] lane_a;
            logic [IN_WIDTH-1:0] lane_b;
            assign lane_a = data_i[(2*gi)*IN_WIDTH +: IN_WIDTH];
            assign lane_b = data_i[(2*gi+1)*IN_WIDTH +: IN_WIDTH];
            assign pair_sum[gi*OUT_W +: OUT_W] = {lane_a[IN_WIDTH-1], lane_a}
                                               + {lane_b[IN_WIDTH-1], lane_b};
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en) begin
            valid_d = valid_i;
            data_d  = pair_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/featuremap_accum_act.sv
// Reduces NUM_CH channel results to one output pixel: pipelined adder tree,
// bias add, optional leaky ReLU, saturation, frame pixel counter and bias port.
module featuremap_accum_act
    import layer_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRAC_BITS   = FRAC_BITS_DEF,
    parameter int IMG_SIZE    = 104,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    input  logic [DATA_WIDTH-1:0]        bias_in,
    input  logic                         bias_we,
    input  logic                         act_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic                         last_out,
    output logic                         bias_err
);

    localparam int L       = tree_depth(NUM_CH);
    localparam int TREE_W  = DATA_WIDTH + L;
    localparam int ACC_W   = acc_width(DATA_WIDTH, NUM_CH);
    localparam int PIX     = IMG_SIZE * IMG_SIZE;
    localparam int CNT_W   = (PIX > 1) ? $clog2(PIX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX - 1);

    generate
        if ((NUM_CH < 2) || ((NUM_CH & (NUM_CH - 1)) != 0)) begin : g_bad_num_ch
            $error("featuremap_accum_act: NUM_CH must be a power of two >= 2");
        end
        if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
            $error("featuremap_accum_act: FRAC_BITS must be below DATA_WIDTH");
        end
        if (ACC_W > CALC_W) begin : g_bad_acc
            $error("featuremap_accum_act: accumulator wider than calculation carrier");
        end
    endgenerate

    logic en;
    logic idle;

    logic [L-1:0]      lvl_valid;
    logic [TREE_W-1:0] tree_data;

    logic                    b_valid_d;
    logic                    b_valid_q;
    logic signed [ACC_W-1:0] b_sum_d;
    logic signed [ACC_W-1:0] b_sum_q;

    logic [DATA_WIDTH-1:0] bias_d;
    logic [DATA_WIDTH-1:0] bias_q;
    logic                  bias_err_d;
    logic                  bias_err_q;

    calc_t                 act_val;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_out_d;
    logic                  valid_out_q;

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // One global enable: the whole pipe freezes only when a result is waiting
    // on a downstream that is not ready.
    assign en        = !(valid_out_q && !ready_in);
    assign ready_out = en;

    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_lvl
            localparam int NI = NUM_CH >> gi;
            localparam int IW = DATA_WIDTH + gi;
            logic [(NI/2)*(IW+1)-1:0] lvl_data;

            if (gi == 0) begin : g_first
                featuremap_add_level #(
                    .N_IN     (NI),
                    .IN_WIDTH (IW)
                ) u_level (
                    .clk     (Clk),
                    .rst_n   (Rst),
                    .en      (en),
                    .valid_i (valid_in),
                    .data_i  (data_in),
                    .valid_o (lvl_valid[gi]),
                    .data_o  (lvl_data)
                );
            end else begin : g_next
                featuremap_add_level #(
                    .N_IN     (NI),
                    .IN_WIDTH (IW)
                ) u_level (
                    .clk     (Clk),
                    .rst_n   (Rst),
                    .en      (en),
                    .valid_i (lvl_valid[gi-1]),
                    .data_i  (g_lvl[gi-1].lvl_data),
                    .valid_o (lvl_valid[gi]),
                    .data_o  (lvl_data)
                );
            end
        end
    endgenerate

    assign tree_data = g_lvl[L-1].lvl_data;

    // The bias may only change while nothing is in flight, so every pixel of
    // a frame sees the same bias.
    assign idle = !(|lvl_valid) && !b_valid_q && !valid_out_q && !valid_in;

    always_comb begin
        bias_d     = bias_q;
        bias_err_d = 1'b0;
        if (bias_we) begin
            if (idle) begin
                bias_d = bias_in;
            end else begin
                bias_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        b_valid_d = b_valid_q;
        b_sum_d   = b_sum_q;
        if (en) begin
            b_valid_d = lvl_valid[L-1];
            b_sum_d   = $signed({{(ACC_W-TREE_W){tree_data[TREE_W-1]}}, tree_data})
                      + $signed({{(ACC_W-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q});
        end
    end

    always_comb begin
        act_val = calc_t'(b_sum_q);
        if (act_en) begin
            act_val = leaky(calc_t'(b_sum_q), LEAKY_SHIFT);
        end
    end

    always_comb begin
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        if (en) begin
            valid_out_d = b_valid_q;
            if (b_valid_q) begin
                data_out_d = DATA_WIDTH'(sat_to_width(act_val, DATA_WIDTH));
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (valid_out_q && ready_in) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            b_valid_q   <= 1'b0;
            b_sum_q     <= '0;
            bias_q      <= '0;
            bias_err_q  <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            b_valid_q   <= b_valid_d;
            b_sum_q     <= b_sum_d;
            bias_q      <= bias_d;
            bias_err_q  <= bias_err_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            cnt_q       <= cnt_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign last_out  = valid_out_q && (cnt_q == CNT_LAST);
    assign bias_err  = bias_err_q;

endmodule

// File: tb/tb_featuremap_accum_act.sv
// Bench for featuremap_accum_act: queue-based reference of accepted beats,
// per-cycle output comparison, directed literal cases and random streaming.
module tb_featuremap_accum_act;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int IMG = 2;
    localparam int LS  = 3;
    localparam int PIX = IMG * IMG;
    localparam int OUT_AGE = 3;

    logic                clk_s = 1'b0;
    logic                Rst = 1'b0;
    logic [NCH*DW-1:0]   data_in = '0;
    logic                valid_in = 1'b0;
    logic                ready_out;
    logic [DW-1:0]       bias_in = '0;
    logic                bias_we = 1'b0;
    logic                act_en = 1'b0;
    logic [DW-1:0]       data_out;
    logic                valid_out;
    logic                ready_in = 1'b1;
    logic                last_out;
    logic                bias_err;

    featuremap_accum_act #(
        .NUM_CH      (NCH),
        .DATA_WIDTH  (DW),
        .FRAC_BITS   (8),
        .IMG_SIZE    (IMG),
        .LEAKY_SHIFT (LS)
    ) dut (
        .Clk       (clk_s),
        .Rst       (Rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .bias_in   (bias_in),
        .bias_we   (bias_we),
        .act_en    (act_en),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .last_out  (last_out),
        .bias_err  (bias_err)
    );

    always #5 clk_s = ~clk_s;

    typedef struct {
        int val;
        int age;
    } item_t;

    item_t q[$];
    int    bias_m = 0;
    int    cnt_m = 0;
    bit    exp_err = 0;
    bit    rst_seen = 0;
    bit    prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    bit    armed = 0;
    int    hs_idx = 0;
    int    last_pos[$];
    int    err_pulses = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic check(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Pixel value from first principles: integer sum, bias, floor shift, clamp.
    function automatic int ref_pixel(input logic [NCH*DW-1:0] d, input int b, input bit act);
        int s;
        s = b;
        for (int k = 0; k < NCH; k++) begin
            s += int'($signed(d[k*DW +: DW]));
        end
        if (act && s < 0) begin
            s = s >>> LS;
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    always @(negedge clk_s) begin
        bit head_ready;
        bit en_m;
        bit idle_m;
        head_ready = (q.size() > 0) && (q[0].age >= OUT_AGE);
        if (armed) begin
            if (rst_seen) begin
                check("reset_data_out", data_out, 0);
                rst_seen = 0;
            end
            check("ready_out", ready_out, !(valid_out && !ready_in));
            check("bias_err", bias_err, exp_err);
            check("valid_out", valid_out, head_ready);
            if (head_ready) begin
                check("data_out", int'($signed(data_out)), q[0].val);
                check("last_out", last_out, cnt_m == PIX - 1);
            end else begin
                check("last_out_idle", last_out, 0);
            end
            if (prev_stall) begin
                check("stall_hold", data_out, prev_data);
            end
            if (bias_err) err_pulses++;
            if (valid_out && ready_in) begin
                hs_idx++;
                if (last_out) last_pos.push_back(hs_idx);
            end
        end
        armed = 1;
        prev_stall = valid_out && !ready_in;
        prev_data  = data_out;
        if (!Rst) begin
            q.delete();
            cnt_m = 0;
            bias_m = 0;
            exp_err = 0;
            prev_stall = 0;
            rst_seen = 1;
            hs_idx = 0;
            last_pos.delete();
        end else begin
            en_m   = !(head_ready && !ready_in);
            idle_m = (q.size() == 0) && !valid_in;
            exp_err = bias_we && !idle_m;
            if (bias_we && idle_m) bias_m = int'($signed(bias_in));
            if (head_ready && ready_in) begin
                void'(q.pop_front());
                cnt_m = (cnt_m == PIX - 1) ? 0 : cnt_m + 1;
            end
            if (en_m) begin
                foreach (q[i]) q[i].age++;
                if (valid_in) q.push_back('{ref_pixel(data_in, bias_m, act_en), 0});
            end
        end
    end

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 300 && q.size() != 0; i++) tick();
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
    endtask

    task automatic set_bias(input logic [DW-1:0] b);
        bias_in = b;
        bias_we = 1'b1;
        tick();
        bias_we = 1'b0;
    endtask

    task automatic send_beat(input logic [NCH*DW-1:0] d);
        bit acc;
        acc = 0;
        data_in  = d;
        valid_in = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk_s);
            acc = ready_out;
            tick();
        end
        valid_in = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic single(input logic [NCH*DW-1:0] d, input logic [DW-1:0] b, input bit set_b,
                          input bit act, input logic [DW-1:0] exp, input string nm);
        wait_drain();
        if (set_b) set_bias(b);
        act_en   = act;
        ready_in = 1'b1;
        data_in  = d;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        check({nm, "_early"}, valid_out, 0);
        tick();
        check({nm, "_valid"}, valid_out, 1);
        check({nm, "_data"}, data_out, exp);
        $display("single %s: data_out=%h expected=%h", nm, data_out, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int e0;
        repeat (3) tick();
        check("reset_valid_out", valid_out, 0);
        check("reset_bias_err", bias_err, 0);
        Rst = 1'b1;
        tick();

        single({16'h0080, 16'hFF00, 16'h0200, 16'h0100}, 16'h0100, 1, 1, 16'h0380, "t1");
        single({4{16'hF000}}, 16'h0000, 1, 1, 16'hF800, "t2_leaky");
        single({4{16'hF000}}, 16'h0000, 0, 0, 16'hC000, "t2_linear");
        single({4{16'h8000}}, 16'h0000, 0, 0, 16'h8000, "t2_negsat");
        single({4{16'h7FFF}}, 16'h7FFF, 1, 0, 16'h7FFF, "t3_possat");

        // Stall in the middle of a 4-beat stream.
        wait_drain();
        set_bias(16'h0010);
        act_en = 1'b1;
        hs0 = hs_idx;
        fork
            begin
                for (int i = 0; i < 4; i++) send_beat({$urandom, $urandom});
            end
            begin
                repeat (5) tick();
                ready_in = 1'b0;
                #1;
                check("t4_stall_ready", ready_out, 0);
                repeat (3) tick();
                ready_in = 1'b1;
            end
        join
        wait_drain();
        check("t4_count", hs_idx - hs0, 4);
        $display("t4: %0d outputs after stall", hs_idx - hs0);

        // Two frames back to back from a clean counter.
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        act_en = 1'b0;
        for (int i = 0; i < 8; i++) send_beat({$urandom, $urandom});
        wait_drain();
        check("t5_last_count", last_pos.size(), 2);
        if (last_pos.size() == 2) begin
            check("t5_last_first", last_pos[0], 4);
            check("t5_last_second", last_pos[1], 8);
        end
        $display("t5: %0d last markers", last_pos.size());

        // Bias write with a beat in flight is rejected.
        set_bias(16'h0040);
        e0 = err_pulses;
        data_in  = '0;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        bias_in  = 16'h1234;
        bias_we  = 1'b1;
        tick();
        bias_we  = 1'b0;
        check("t6_err_now", bias_err, 1);
        wait_drain();
        check("t6_err_once", err_pulses - e0, 1);
        single('0, 16'h0000, 0, 0, 16'h0040, "t6_bias_kept");

        // Reset with beats in flight, then a fresh frame.
        data_in  = {4{16'h0100}};
        valid_in = 1'b1;
        tick();
        tick();
        valid_in = 1'b0;
        Rst = 1'b0;
        tick();
        check("t6_reset_valid", valid_out, 0);
        Rst = 1'b1;
        for (int i = 0; i < 4; i++) send_beat({$urandom, $urandom});
        wait_drain();
        check("t6_last_count", last_pos.size(), 1);
        if (last_pos.size() == 1) check("t6_last_pos", last_pos[0], 4);

        // Random streaming with back-pressure and stray bias writes.
        for (int b = 0; b < 3; b++) begin
            wait_drain();
            act_en = b[0];
            for (int c = 0; c < 150; c++) begin
                valid_in = ($urandom_range(0, 9) < 7);
                data_in  = {$urandom, $urandom};
                ready_in = ($urandom_range(0, 3) != 0);
                bias_we  = ($urandom_range(0, 19) == 0);
                bias_in  = DW'($urandom);
                tick();
            end
            valid_in = 1'b0;
            bias_we  = 1'b0;
            ready_in = 1'b1;
            wait_drain();
            $display("random burst %0d: act_en=%0d outputs so far %0d", b, act_en, hs_idx);
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
